kw_rol_iter: RTL and testbench

//  Multi-cycle rotate-LEFT engine with a variable amount.
//  - Consumes one amount bit per cycle as a log-stage rotator: stage k rotates left by 2**k if amt[k] is set.
//  - Counterpart to the static rotate-right: use it where the amount is dynamic and area beats latency.
//  - Valid/ready on both sides; holds exactly one operation at a time.

---
 rtl/kw_rol_iter.sv | 160 ++++++++++++++++
 tb/tb_kw_rol_iter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/kw_rol_iter.sv
// Multi-cycle variable rotate-left engine: one amount bit per BUSY cycle, valid/ready on both sides.
// Optional build macro KW_ROL_EARLY_EXIT_EN ends the BUSY phase once no higher amount bits remain set.
module kw_rol_iter #(
   parameter  int WIDTH = 8,
   localparam int AW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [AW-1:0]    in_amt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [AW-1:0] LAST_STAGE = AW'(AW - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [AW-1:0]    amt_q, amt_d;
   logic [AW-1:0]    stage_q, stage_d;
   logic             in_ready_q, out_valid_q;
   logic             amt_bit_s;

   // Rotate left by s, where s is already reduced below WIDTH.
   function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x, input logic [AW-1:0] s);
      return WIDTH'(({x, x} << s) >> WIDTH);
   endfunction

   // Stage k rotates by 2**k; reducing mod WIDTH keeps non-power-of-2 widths exact.
   function automatic logic [AW-1:0] stage_shift(input logic [AW-1:0] k);
      return AW'((32'd1 << k) % 32'(WIDTH));
   endfunction

   assign amt_bit_s = |(amt_q & (AW'(1) << stage_q));

   // Next-state and datapath decode for the IDLE/BUSY/DONE sequence.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      amt_d   = amt_q;
      stage_d = stage_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready_q) begin
               data_d  = in_data;
               amt_d   = in_amt;
               stage_d = '0;
`ifdef KW_ROL_EARLY_EXIT_EN
               if (in_amt == '0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_BUSY;
               end
`else
               state_d = ST_BUSY;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (amt_bit_s) begin
               data_d = rotl(data_q, stage_shift(stage_q));
            end else begin
               data_d = data_q;
            end
            stage_d = stage_q + AW'(1);
`ifdef KW_ROL_EARLY_EXIT_EN
            if (((amt_q >> stage_q) >> 1) == '0) begin
`else
            if (stage_q == LAST_STAGE) begin
`endif
               state_d = ST_DONE;
               stage_d = '0;
            end else begin
               state_d = ST_BUSY;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            stage_d = '0;
         end
      endcase
   end

   // State, operand and handshake-flag registers; flags are precomputed from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         data_q      <= '0;
         amt_q       <= '0;
         stage_q     <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         amt_q       <= amt_d;
         stage_q     <= stage_d;
         in_ready_q  <= (state_d == ST_IDLE);
         out_valid_q <= (state_d == ST_DONE);
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = data_q;

`ifndef SYNTHESIS
   kw_rol_iter_chk #(.WIDTH(WIDTH)) u_chk (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_ready  (in_ready_q),
      .out_valid (out_valid_q),
      .out_ready (out_ready),
      .out_data  (data_q)
   );
`endif

endmodule

`ifndef SYNTHESIS
// Simulation-only protocol checks for kw_rol_iter.
module kw_rol_iter_chk #(
   parameter int WIDTH = 8
) (
   input logic             clk,
   input logic             rst_n,
   input logic             in_ready,
   input logic             out_valid,
   input logic             out_ready,
   input logic [WIDTH-1:0] out_data
);

   a_width_min: assert property (@(posedge clk) WIDTH >= 2);

   a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready) |=> ($stable(out_data) && out_valid));

   a_no_x: assert property (@(posedge clk) disable iff (!rst_n)
      !$isunknown({out_valid, in_ready}));

endmodule
`endif

// File: tb/tb_kw_rol_iter.sv
// Directed bench for kw_rol_iter at WIDTH=8 plus a WIDTH=5 instance checked against a bit-loop model.
module tb_kw_rol_iter;

   logic       clk;
   logic       rst_n;
   logic       in_valid, in_ready, out_valid, out_ready;
   logic [7:0] in_data, out_data;
   logic [2:0] in_amt;
   logic       in_valid5, in_ready5, out_valid5, out_ready5;
   logic [4:0] in_data5, out_data5;
   logic [2:0] in_amt5;

   int n_checks = 0;
   int n_pass   = 0;

   kw_rol_iter #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_amt(in_amt),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
   );

   kw_rol_iter #(.WIDTH(5)) dut5 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid5), .in_ready(in_ready5), .in_data(in_data5), .in_amt(in_amt5),
      .out_valid(out_valid5), .out_ready(out_ready5), .out_data(out_data5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int exp_lat(input logic [2:0] a);
`ifdef KW_ROL_EARLY_EXIT_EN
      if (a[2]) return 3;
      else if (a[1]) return 2;
      else if (a[0]) return 1;
      else return 0;
`else
      return 3;
`endif
   endfunction

   function automatic logic [4:0] rotl5(input logic [4:0] x, input int s);
      logic [4:0] r;
      for (int i = 0; i < 5; i++) r[(i + s) % 5] = x[i];
      return r;
   endfunction

   task automatic op8(input logic [7:0] d, input logic [2:0] a, input logic [7:0] exp, input string tag);
      int lat;
      @(negedge clk);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_data = d; in_amt = a; out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0; in_data = ~d; in_amt = ~a;
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) break;
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat(a)));
      check({tag, "_data"}, 32'(out_data), 32'(exp));
      @(negedge clk);
      check({tag, "_idle"}, 32'({out_valid, in_ready}), 32'b01);
   endtask

   task automatic op5(input logic [4:0] d, input logic [2:0] a, input string tag, input bit bp);
      bit got;
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         if (in_ready5) break;
         @(negedge clk);
      end
      check({tag, "_in_ready"}, 32'(in_ready5), 32'd1);
      in_valid5 = 1'b1; in_data5 = d; in_amt5 = a;
      @(posedge clk);
      #1;
      in_valid5 = 1'b0; in_data5 = ~d;
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         out_ready5 = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         if (out_valid5 && out_ready5) begin
            got = 1'b1;
            check({tag, "_data"}, 32'(out_data5), 32'(rotl5(d, int'(a))));
            break;
         end
      end
      if (!got) check({tag, "_timeout"}, 32'(got), 32'd1);
      @(posedge clk);
      #1;
      out_ready5 = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0; in_data = 8'h00; in_amt = 3'd0; out_ready = 1'b0;
      in_valid5 = 1'b0; in_data5 = 5'd0; in_amt5 = 3'd0; out_ready5 = 1'b0;
      #12;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst5_flags", 32'({in_ready5, out_valid5}), 32'b10);
      @(negedge clk);
      rst_n = 1'b1;

      op8(8'h81, 3'd1, 8'h03, "rol_81_1");
      op8(8'hA5, 3'd4, 8'h5A, "rol_A5_4");
      op8(8'h12, 3'd7, 8'h09, "rol_12_7");
      op8(8'h3C, 3'd0, 8'h3C, "rol_3C_0");
      op8(8'h81, 3'd2, 8'h06, "rol_81_2");
      op8(8'hF0, 3'd3, 8'h87, "rol_F0_3");
      op8(8'h01, 3'd5, 8'h20, "rol_01_5");

      // Backpressure: result must hold while out_ready stays low.
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'hC3; in_amt = 3'd6; out_ready = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) break;
      end
      for (int i = 0; i < 5; i++) begin
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_out_data", 32'(out_data), 32'hF0);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         in_valid = 1'b1; in_data = 8'h55; in_amt = 3'd1;
         @(negedge clk);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      check("bp_release", 32'({out_valid, in_ready}), 32'b01);

      // Reset in the middle of BUSY aborts the operation.
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'hFF; in_amt = 3'd7;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_out_data", 32'(out_data), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      op8(8'h01, 3'd2, 8'h04, "post_rst");

      op5(5'b00001, 3'd7, "w5_01_7", 1'b0);
      check("w5_expect", 32'(rotl5(5'b00001, 7)), 32'b00100);
      for (int n = 0; n < 2000; n++) begin
         op5(5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), "w5_rand", 1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
